calc_sequencer: RTL and testbench

- Keypad-driven controller that sequences the 8-bit BCD ALU for the calculator top level.
- Assembles two 2-digit BCD operands from key events and latches the operator.
- Drives the ALU operand and one-hot select inputs for a fixed settle window, then captures the 16-bit result and status into display registers.
- Handles clear, operator chaining, and the divide-by-zero error state.

---
 rtl/calc_pkg.sv | 47 ++++
 rtl/calc_operand_reg.sv | 40 ++++
 rtl/calc_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad sequencer: key codes,
// FSM state encoding, operator encoding and key-classification helpers.
package calc_pkg;

    localparam logic [4:0] KEY_ADD = 5'h0A;
    localparam logic [4:0] KEY_SUB = 5'h0B;
    localparam logic [4:0] KEY_MUL = 5'h0C;
    localparam logic [4:0] KEY_DIV = 5'h0D;
    localparam logic [4:0] KEY_EQ  = 5'h0E;
    localparam logic [4:0] KEY_CLR = 5'h0F;

    // Encoding is visible on the dbg_state output of calc_sequencer.
    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_SHOW    = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    function automatic logic is_digit(input logic [4:0] key_code);
        return key_code <= 5'h09;
    endfunction

    function automatic logic is_op(input logic [4:0] key_code);
        return (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
    endfunction

    function automatic op_t key_to_op(input logic [4:0] key_code);
        op_t op;
        case (key_code)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_operand_reg.sv
// Two-digit packed-BCD operand register. New digits shift in at the low
// nibble and the oldest digit falls off the top. Clear beats load beats shift.
module calc_operand_reg (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       shift_i,
    input  logic [3:0] digit_i,
    output logic [7:0] value_o
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    // Select the next operand value from the control strobes.
    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = 8'h00;
        end else if (load_i) begin
            value_d = load_val_i;
        end else if (shift_i) begin
            value_d = {value_q[3:0], digit_i};
        end
    end

    // Operand storage with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= 8'h00;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer for the 8-bit BCD ALU: builds operands from key
// events, holds the ALU inputs/select for a settle window, then captures the
// result into display registers. Handles clear, chaining and divide-by-zero.
//
// Key interface: key_valid is a single-cycle strobe with no back-pressure;
// key_code is only meaningful while key_valid is high and a key that the
// current state does not accept is dropped, never queued.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        sel_add,
    output logic        sel_sub,
    output logic        sel_mul,
    output logic        sel_div,
    input  logic [15:0] alu_result,
    input  logic        alu_status,
    output logic [15:0] disp_value,
    output logic        disp_flag,
    output logic        disp_err,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic              b_entered_q, b_entered_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       disp_q, disp_d;
    logic              flag_q, flag_d;
    logic              done_q, done_d;

    logic       a_clr, a_load, a_shift, b_clr, b_shift;
    logic [7:0] a_load_val;

    logic key_clr, key_dig, key_op, key_eq, capture, div_zero;

    assign key_clr  = key_valid && (key_code == KEY_CLR);
    assign key_dig  = key_valid && is_digit(key_code);
    assign key_op   = key_valid && is_op(key_code);
    assign key_eq   = key_valid && (key_code == KEY_EQ);
    assign capture  = (state_q == ST_EXEC) && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
    assign div_zero = (op_q == OP_DIV) && (alu_b == 8'h00);

    // FSM state register; reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode from the accepted key or the settle counter.
    always_comb begin
        state_d = state_q;
        if (key_clr) begin
            state_d = ST_ENTER_A;
        end else begin
            case (state_q)
                ST_ENTER_A: if (key_op) state_d = ST_ENTER_B;
                ST_ENTER_B: if (key_eq) state_d = ST_EXEC;
                ST_EXEC:    if (capture) state_d = div_zero ? ST_ERR : ST_SHOW;
                ST_SHOW: begin
                    if (key_dig)     state_d = ST_ENTER_A;
                    else if (key_op) state_d = ST_ENTER_B;
                end
                default:    state_d = state_q;
            endcase
        end
    end

    // Per-state datapath controls and next values of the capture registers.
    always_comb begin
        a_clr       = key_clr;
        b_clr       = key_clr;
        a_load      = 1'b0;
        a_load_val  = 8'h00;
        a_shift     = 1'b0;
        b_shift     = 1'b0;
        op_d        = op_q;
        b_entered_d = b_entered_q;
        cnt_d       = cnt_q;
        disp_d      = disp_q;
        flag_d      = flag_q;
        done_d      = 1'b0;
        if (key_clr) begin
            op_d        = OP_ADD;
            b_entered_d = 1'b0;
            cnt_d       = '0;
            disp_d      = 16'h0000;
            flag_d      = 1'b0;
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (key_dig) begin
                        a_shift = 1'b1;
                    end else if (key_op) begin
                        op_d        = key_to_op(key_code);
                        b_clr       = 1'b1;
                        b_entered_d = 1'b0;
                    end
                end
                ST_ENTER_B: begin
                    if (key_dig) begin
                        b_shift     = 1'b1;
                        b_entered_d = 1'b1;
                    end else if (key_op && !b_entered_q) begin
                        op_d = key_to_op(key_code);
                    end else if (key_eq) begin
                        cnt_d = '0;
                    end
                end
                ST_EXEC: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (capture) begin
                        done_d = 1'b1;
                        if (div_zero) begin
                            disp_d = 16'hFFFF;
                        end else begin
                            disp_d = alu_result;
                            flag_d = alu_status;
                        end
                    end
                end
                ST_SHOW: begin
                    if (key_dig) begin
                        a_load     = 1'b1;
                        a_load_val = {4'h0, key_code[3:0]};
                        b_clr      = 1'b1;
                        flag_d     = 1'b0;
                    end else if (key_op) begin
                        // Chaining reuses the low result byte verbatim.
                        a_load      = 1'b1;
                        a_load_val  = disp_q[7:0];
                        op_d        = key_to_op(key_code);
                        b_clr       = 1'b1;
                        b_entered_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operator, entry flag, settle counter and display capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_ADD;
            b_entered_q <= 1'b0;
            cnt_q       <= '0;
            disp_q      <= 16'h0000;
            flag_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            op_q        <= op_d;
            b_entered_q <= b_entered_d;
            cnt_q       <= cnt_d;
            disp_q      <= disp_d;
            flag_q      <= flag_d;
            done_q      <= done_d;
        end
    end

    calc_operand_reg u_opa (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (a_clr),
        .load_i     (a_load),
        .load_val_i (a_load_val),
        .shift_i    (a_shift),
        .digit_i    (key_code[3:0]),
        .value_o    (alu_a)
    );

    calc_operand_reg u_opb (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (b_clr),
        .load_i     (1'b0),
        .load_val_i (8'h00),
        .shift_i    (b_shift),
        .digit_i    (key_code[3:0]),
        .value_o    (alu_b)
    );

    assign sel_add   = (state_q == ST_EXEC) && (op_q == OP_ADD);
    assign sel_sub   = (state_q == ST_EXEC) && (op_q == OP_SUB);
    assign sel_mul   = (state_q == ST_EXEC) && (op_q == OP_MUL);
    assign sel_div   = (state_q == ST_EXEC) && (op_q == OP_DIV);
    assign busy      = (state_q == ST_EXEC);
    assign disp_err  = (state_q == ST_ERR);
    assign disp_flag = flag_q;
    assign done      = done_q;
    assign dbg_state = state_q;
    assign disp_value = (state_q == ST_ENTER_A) ? {8'h00, alu_a} :
                        ((state_q == ST_ENTER_B) || (state_q == ST_EXEC)) ? {8'h00, alu_b} :
                        disp_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural BCD ALU model.
module tb_calc_sequencer;

    localparam logic [2:0] S_EA = 3'd0;
    localparam logic [2:0] S_EB = 3'd1;
    localparam logic [2:0] S_EX = 3'd2;
    localparam logic [2:0] S_SH = 3'd3;
    localparam logic [2:0] S_ER = 3'd4;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_ADD  = 4'b1000;
    localparam logic [3:0] SEL_SUB  = 4'b0100;
    localparam logic [3:0] SEL_MUL  = 4'b0010;
    localparam logic [3:0] SEL_DIV  = 4'b0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [7:0]  alu_a, alu_b;
    logic        sel_add, sel_sub, sel_mul, sel_div;
    logic [15:0] alu_result;
    logic        alu_status;
    logic [15:0] disp_value;
    logic        disp_flag, disp_err, busy, done;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    // clock / reset
    always #5 clk = ~clk;

    calc_sequencer #(.SETTLE_CYCLES(2), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .sel_add    (sel_add),
        .sel_sub    (sel_sub),
        .sel_mul    (sel_mul),
        .sel_div    (sel_div),
        .alu_result (alu_result),
        .alu_status (alu_status),
        .disp_value (disp_value),
        .disp_flag  (disp_flag),
        .disp_err   (disp_err),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Behavioural ALU: BCD add/sub/div, binary multiply.
    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        r[3:0]   = 4'(n % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[15:12] = 4'((n / 1000) % 10);
        return r;
    endfunction

    function automatic logic [16:0] alu_model(input logic [3:0] sel, input logic [7:0] a,
                                              input logic [7:0] b);
        int da, db, r;
        logic st;
        logic [15:0] res;
        da  = bcd2int(a);
        db  = bcd2int(b);
        st  = 1'b0;
        res = 16'h0000;
        if (sel[3]) begin
            r   = da + db;
            res = int2bcd(r);
            st  = (r > 99);
        end else if (sel[2]) begin
            r = da - db;
            if (r < 0) begin
                r  = r + 100;
                st = 1'b1;
            end
            res = int2bcd(r);
        end else if (sel[1]) begin
            res = 16'(da * db);
        end else if (sel[0]) begin
            res = (db == 0) ? 16'h0000 : int2bcd(da / db);
        end
        return {st, res};
    endfunction

    assign {alu_status, alu_result} =
        alu_model({sel_add, sel_sub, sel_mul, sel_div}, alu_a, alu_b);

    // Expected-output packing: a, b, disp, state, sel, done, err, flag, busy.
    function automatic logic [42:0] mk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [15:0] d, input logic [2:0] st,
                                       input logic [3:0] sel, input logic dn,
                                       input logic er, input logic fl);
        return {a, b, d, st, sel, dn, er, fl, (st == S_EX)};
    endfunction

    function automatic logic [42:0] got();
        return {alu_a, alu_b, disp_value, dbg_state, sel_add, sel_sub, sel_mul, sel_div,
                done, disp_err, disp_flag, busy};
    endfunction

    // scoreboard compare
    task automatic check(input string name, input logic [42:0] exp);
        logic [42:0] g;
        g = got();
        checks++;
        if (g !== exp) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h disp=%h st=%0d sel=%b done=%b err=%b flag=%b busy=%b | required a=%h b=%h disp=%h st=%0d sel=%b done=%b err=%b flag=%b busy=%b",
                     name, g[42:35], g[34:27], g[26:11], g[10:8], g[7:4], g[3], g[2], g[1], g[0],
                     exp[42:35], exp[34:27], exp[26:11], exp[10:8], exp[7:4], exp[3], exp[2],
                     exp[1], exp[0]);
        end
    endtask

    // driver: present one key (or idle) for one cycle, return at next negedge
    task automatic step(input logic v, input logic [4:0] k);
        key_valid = v;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 5'h00;
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  k;
        logic [42:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [4:0] k, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] d, input logic [2:0] st,
                       input logic [3:0] sel, input logic dn, input logic er, input logic fl);
        vec_t r;
        r.v   = v;
        r.k   = k;
        r.exp = mk(a, b, d, st, sel, dn, er, fl);
        vecs.push_back(r);
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 5'h00;

        // 45 + 38 = 83, ignored keys, key dropped in EXEC
        add(1, 5'h15, 8'h00, 8'h00, 16'h0000, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h04, 8'h04, 8'h00, 16'h0004, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h05, 8'h45, 8'h00, 16'h0045, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h0E, 8'h45, 8'h00, 16'h0045, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h0A, 8'h45, 8'h00, 16'h0000, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h15, 8'h45, 8'h00, 16'h0000, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h03, 8'h45, 8'h03, 16'h0003, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h08, 8'h45, 8'h38, 16'h0038, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h0E, 8'h45, 8'h38, 16'h0038, S_EX, SEL_ADD,  0, 0, 0);
        add(1, 5'h01, 8'h45, 8'h38, 16'h0038, S_EX, SEL_ADD,  0, 0, 0);
        add(0, 5'h00, 8'h45, 8'h38, 16'h0083, S_SH, SEL_NONE, 1, 0, 0);
        add(1, 5'h15, 8'h45, 8'h38, 16'h0083, S_SH, SEL_NONE, 0, 0, 0);
        add(1, 5'h0E, 8'h45, 8'h38, 16'h0083, S_SH, SEL_NONE, 0, 0, 0);
        add(1, 5'h0F, 8'h00, 8'h00, 16'h0000, S_EA, SEL_NONE, 0, 0, 0);
        // 1,2,3 keeps the last two digits
        add(1, 5'h01, 8'h01, 8'h00, 16'h0001, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h02, 8'h12, 8'h00, 16'h0012, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h03, 8'h23, 8'h00, 16'h0023, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h0F, 8'h00, 8'h00, 16'h0000, S_EA, SEL_NONE, 0, 0, 0);
        // 5 + - 2 (+ ignored) = 3
        add(1, 5'h05, 8'h05, 8'h00, 16'h0005, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h0A, 8'h05, 8'h00, 16'h0000, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h0B, 8'h05, 8'h00, 16'h0000, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h02, 8'h05, 8'h02, 16'h0002, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h0A, 8'h05, 8'h02, 16'h0002, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h0E, 8'h05, 8'h02, 16'h0002, S_EX, SEL_SUB,  0, 0, 0);
        add(0, 5'h00, 8'h05, 8'h02, 16'h0002, S_EX, SEL_SUB,  0, 0, 0);
        add(0, 5'h00, 8'h05, 8'h02, 16'h0003, S_SH, SEL_NONE, 1, 0, 0);
        add(1, 5'h0F, 8'h00, 8'h00, 16'h0000, S_EA, SEL_NONE, 0, 0, 0);
        // 9 / 0 = error, only clear leaves
        add(1, 5'h09, 8'h09, 8'h00, 16'h0009, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h0D, 8'h09, 8'h00, 16'h0000, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h00, 8'h09, 8'h00, 16'h0000, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h0E, 8'h09, 8'h00, 16'h0000, S_EX, SEL_DIV,  0, 0, 0);
        add(1, 5'h15, 8'h09, 8'h00, 16'h0000, S_EX, SEL_DIV,  0, 0, 0);
        add(0, 5'h00, 8'h09, 8'h00, 16'hFFFF, S_ER, SEL_NONE, 1, 1, 0);
        add(1, 5'h07, 8'h09, 8'h00, 16'hFFFF, S_ER, SEL_NONE, 0, 1, 0);
        add(1, 5'h0E, 8'h09, 8'h00, 16'hFFFF, S_ER, SEL_NONE, 0, 1, 0);
        add(1, 5'h0A, 8'h09, 8'h00, 16'hFFFF, S_ER, SEL_NONE, 0, 1, 0);
        add(1, 5'h15, 8'h09, 8'h00, 16'hFFFF, S_ER, SEL_NONE, 0, 1, 0);
        add(1, 5'h0F, 8'h00, 8'h00, 16'h0000, S_EA, SEL_NONE, 0, 0, 0);
        // 2 * 3 = 6, then chain + 4 = 10
        add(1, 5'h02, 8'h02, 8'h00, 16'h0002, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h0C, 8'h02, 8'h00, 16'h0000, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h03, 8'h02, 8'h03, 16'h0003, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h0E, 8'h02, 8'h03, 16'h0003, S_EX, SEL_MUL,  0, 0, 0);
        add(0, 5'h00, 8'h02, 8'h03, 16'h0003, S_EX, SEL_MUL,  0, 0, 0);
        add(0, 5'h00, 8'h02, 8'h03, 16'h0006, S_SH, SEL_NONE, 1, 0, 0);
        add(1, 5'h0A, 8'h06, 8'h00, 16'h0000, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h04, 8'h06, 8'h04, 16'h0004, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h0E, 8'h06, 8'h04, 16'h0004, S_EX, SEL_ADD,  0, 0, 0);
        add(0, 5'h00, 8'h06, 8'h04, 16'h0004, S_EX, SEL_ADD,  0, 0, 0);
        add(0, 5'h00, 8'h06, 8'h04, 16'h0010, S_SH, SEL_NONE, 1, 0, 0);
        add(1, 5'h0F, 8'h00, 8'h00, 16'h0000, S_EA, SEL_NONE, 0, 0, 0);
        // 99 + 01 carries; a digit from SHOW clears the flag
        add(1, 5'h09, 8'h09, 8'h00, 16'h0009, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h09, 8'h99, 8'h00, 16'h0099, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h0A, 8'h99, 8'h00, 16'h0000, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h00, 8'h99, 8'h00, 16'h0000, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h01, 8'h99, 8'h01, 16'h0001, S_EB, SEL_NONE, 0, 0, 0);
        add(1, 5'h0E, 8'h99, 8'h01, 16'h0001, S_EX, SEL_ADD,  0, 0, 0);
        add(0, 5'h00, 8'h99, 8'h01, 16'h0001, S_EX, SEL_ADD,  0, 0, 0);
        add(0, 5'h00, 8'h99, 8'h01, 16'h0100, S_SH, SEL_NONE, 1, 0, 1);
        add(0, 5'h00, 8'h99, 8'h01, 16'h0100, S_SH, SEL_NONE, 0, 0, 1);
        add(1, 5'h03, 8'h03, 8'h00, 16'h0003, S_EA, SEL_NONE, 0, 0, 0);
        add(1, 5'h0F, 8'h00, 8'h00, 16'h0000, S_EA, SEL_NONE, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("reset", mk(8'h00, 8'h00, 16'h0000, S_EA, SEL_NONE, 0, 0, 0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].k);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // keys with an idle cycle between them
        step(1, 5'h04);
        step(0, 5'h00);
        step(1, 5'h05);
        check("gap_keys", mk(8'h45, 8'h00, 16'h0045, S_EA, SEL_NONE, 0, 0, 0));
        step(1, 5'h0F);

        // reset in the second EXEC cycle wins over capture, no done
        step(1, 5'h01);
        step(1, 5'h0A);
        step(1, 5'h02);
        step(1, 5'h0E);
        check("exec1_pre_rst", mk(8'h01, 8'h02, 16'h0002, S_EX, SEL_ADD, 0, 0, 0));
        step(0, 5'h00);
        check("exec2_pre_rst", mk(8'h01, 8'h02, 16'h0002, S_EX, SEL_ADD, 0, 0, 0));
        rst = 1'b1;
        step(0, 5'h00);
        rst = 1'b0;
        check("rst_mid_exec", mk(8'h00, 8'h00, 16'h0000, S_EA, SEL_NONE, 0, 0, 0));
        step(0, 5'h00);
        check("rst_mid_exec_nodone", mk(8'h00, 8'h00, 16'h0000, S_EA, SEL_NONE, 0, 0, 0));

        // clear mid-EXEC behaves like reset without done
        step(1, 5'h01);
        step(1, 5'h0A);
        step(1, 5'h02);
        step(1, 5'h0E);
        check("exec1_pre_clr", mk(8'h01, 8'h02, 16'h0002, S_EX, SEL_ADD, 0, 0, 0));
        step(1, 5'h0F);
        check("clr_mid_exec", mk(8'h00, 8'h00, 16'h0000, S_EA, SEL_NONE, 0, 0, 0));
        step(0, 5'h00);
        check("clr_mid_exec_nodone", mk(8'h00, 8'h00, 16'h0000, S_EA, SEL_NONE, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
